bus_cycle_ctrl: RTL and testbench

Parametrised bus-cycle controller for the accelerator, clocked from CLKCPU. It terminates CPU cycles that hit any of NUM_REGIONS local fast regions after a per-region programmable wait-state count, and bridges all other cycles to the motherboard by asserting AS_MB_n aligned to the 7 MHz clock. It then relays the motherboard DTACK back to the CPU, and raises a bus error on motherboard timeout. It supersedes the fixed single-region fast DTACK and motherboard AS/DTACK synchronisation logic in the top level.

---
 rtl/bus_cycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_ctrl.sv
// Bus-cycle controller: terminates fast-region CPU cycles after programmable wait
// states, bridges other cycles to the motherboard on C7M, relays DTACK, times out with BERR.
module bus_cycle_ctrl #(
   parameter int NUM_REGIONS = 2,
   parameter int WS_WIDTH    = 3,
   parameter int SYNC_STAGES = 2,
   parameter int MB_TIMEOUT  = 1024
) (
   input  logic                            CLKCPU,
   input  logic                            RESET,
   input  logic                            C7M,
   input  logic                            AS_CPU_n,
   input  logic                            RW_n,
   input  logic                            BR_68SEC000_n,
   input  logic [NUM_REGIONS-1:0]          REGION_HIT,
   input  logic [NUM_REGIONS*WS_WIDTH-1:0] REGION_WS,
   input  logic                            DTACK_MB_n,
   output logic                            AS_MB_n,
   output logic                            DTACK_CPU_n,
   output logic                            BERR_n,
   output logic                            BUSY
);

   localparam int TO_W = (MB_TIMEOUT > 0) ? $clog2(MB_TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MB_TIMEOUT);
   localparam logic [TO_W-1:0] TO_MAX   = {TO_W{1'b1}};
   localparam logic            TO_EN    = (MB_TIMEOUT != 0);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FAST      = 3'd1,
      S_MB_ARM    = 3'd2,
      S_MB_ASSERT = 3'd3,
      S_TERM      = 3'd4
   } state_t;

   state_t                  r_state;
   logic [WS_WIDTH-1:0]     r_ws_cnt;
   logic [TO_W-1:0]         r_to_cnt;
   logic                    r_as_mb_n;
   logic                    r_dtack_n;
   logic                    r_berr_n;
   logic [SYNC_STAGES-1:0]  r_c7m_sync;
   logic                    r_c7m_prev;
   logic [SYNC_STAGES-1:0]  r_dtack_sync;

   logic                    w_c7m_rise;
   logic                    w_dtack_mb_n;
   logic                    w_any_hit;
   logic [WS_WIDTH-1:0]     w_hit_ws;
   logic [TO_W-1:0]         w_to_next;
   logic                    w_unused;

   assign w_unused     = RW_n;
   assign w_c7m_rise   = r_c7m_sync[SYNC_STAGES-1] & ~r_c7m_prev;
   assign w_dtack_mb_n = r_dtack_sync[SYNC_STAGES-1];
   assign w_to_next    = (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + TO_W'(1);

   assign AS_MB_n     = r_as_mb_n;
   assign DTACK_CPU_n = r_dtack_n;
   assign BERR_n      = r_berr_n;
   assign BUSY        = (r_state != S_IDLE);

   // Wait-state field of the lowest-index hit region (scan high to low so low wins)
   always_comb begin
      w_any_hit = |REGION_HIT;
      w_hit_ws  = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         w_hit_ws = REGION_HIT[i] ? REGION_WS[i*WS_WIDTH +: WS_WIDTH] : w_hit_ws;
      end
   end

   // Synchronisers for the asynchronous motherboard clock and DTACK
   always_ff @(posedge CLKCPU or posedge RESET) begin
      if (RESET) begin
         r_c7m_sync   <= '0;
         r_c7m_prev   <= 1'b0;
         r_dtack_sync <= '1;
      end else begin
         r_c7m_sync   <= {r_c7m_sync[SYNC_STAGES-2:0], C7M};
         r_c7m_prev   <= r_c7m_sync[SYNC_STAGES-1];
         r_dtack_sync <= {r_dtack_sync[SYNC_STAGES-2:0], DTACK_MB_n};
      end
   end

   // Cycle FSM with registered bus outputs
   always_ff @(posedge CLKCPU or posedge RESET) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_ws_cnt  <= '0;
         r_to_cnt  <= '0;
         r_as_mb_n <= 1'b1;
         r_dtack_n <= 1'b1;
         r_berr_n  <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_as_mb_n <= 1'b1;
               r_dtack_n <= 1'b1;
               r_berr_n  <= 1'b1;
               if (!AS_CPU_n && BR_68SEC000_n) begin
                  if (w_any_hit) begin
                     r_state  <= S_FAST;
                     r_ws_cnt <= w_hit_ws;
                  end else begin
                     r_state <= S_MB_ARM;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_FAST: begin
               if (AS_CPU_n) begin
                  r_state <= S_IDLE;
               end else if (r_ws_cnt == '0) begin
                  r_dtack_n <= 1'b0;
                  r_state   <= S_TERM;
               end else begin
                  r_ws_cnt <= r_ws_cnt - WS_WIDTH'(1);
               end
            end
            S_MB_ARM: begin
               if (AS_CPU_n) begin
                  r_state <= S_IDLE;
               end else if (w_c7m_rise) begin
                  r_as_mb_n <= 1'b0;
                  r_to_cnt  <= '0;
                  r_state   <= S_MB_ASSERT;
               end else begin
                  r_state <= S_MB_ARM;
               end
            end
            S_MB_ASSERT: begin
               if (AS_CPU_n) begin
                  r_as_mb_n <= 1'b1;
                  r_state   <= S_IDLE;
               end else if (w_c7m_rise) begin
                  // The arming edge resets the count; each later C7M rise adds one
                  r_to_cnt <= w_to_next;
                  if (!w_dtack_mb_n) begin
                     r_dtack_n <= 1'b0;
                     r_state   <= S_TERM;
                  end else if (TO_EN && (w_to_next == TO_LIMIT)) begin
                     r_berr_n <= 1'b0;
                     r_state  <= S_TERM;
                  end else begin
                     r_state <= S_MB_ASSERT;
                  end
               end else begin
                  r_state <= S_MB_ASSERT;
               end
            end
            S_TERM: begin
               if (AS_CPU_n) begin
                  r_as_mb_n <= 1'b1;
                  r_dtack_n <= 1'b1;
                  r_berr_n  <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_state <= S_TERM;
               end
            end
            default: begin
               r_as_mb_n <= 1'b1;
               r_dtack_n <= 1'b1;
               r_berr_n  <= 1'b1;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed self-checking bench for bus_cycle_ctrl; observed vector is
// {AS_MB_n, DTACK_CPU_n, BERR_n, BUSY}, checked 1 ns after each CLKCPU rising edge.
module tb_bus_cycle_ctrl;

   logic       CLKCPU = 1'b0;
   logic       RESET  = 1'b0;
   logic       C7M;
   logic       AS_CPU_n;
   logic       RW_n;
   logic       BR_68SEC000_n;
   logic [1:0] REGION_HIT;
   logic [5:0] REGION_WS;
   logic       DTACK_MB_n;
   logic       AS_MB_n;
   logic       DTACK_CPU_n;
   logic       BERR_n;
   logic       BUSY;
   logic [3:0] obs;

   int n_checks = 0;
   int n_errors = 0;

   assign obs = {AS_MB_n, DTACK_CPU_n, BERR_n, BUSY};

   bus_cycle_ctrl #(
      .NUM_REGIONS(2),
      .WS_WIDTH   (3),
      .SYNC_STAGES(2),
      .MB_TIMEOUT (8)
   ) dut (
      .CLKCPU       (CLKCPU),
      .RESET        (RESET),
      .C7M          (C7M),
      .AS_CPU_n     (AS_CPU_n),
      .RW_n         (RW_n),
      .BR_68SEC000_n(BR_68SEC000_n),
      .REGION_HIT   (REGION_HIT),
      .REGION_WS    (REGION_WS),
      .DTACK_MB_n   (DTACK_MB_n),
      .AS_MB_n      (AS_MB_n),
      .DTACK_CPU_n  (DTACK_CPU_n),
      .BERR_n       (BERR_n),
      .BUSY         (BUSY)
   );

   always #5 CLKCPU = ~CLKCPU;

   task automatic step();
      @(posedge CLKCPU);
      #1;
   endtask

   task automatic idle(input int k);
      AS_CPU_n   = 1'b1;
      C7M        = 1'b0;
      DTACK_MB_n = 1'b1;
      REGION_HIT = 2'b00;
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic test_reset();
      C7M = 1'b0; AS_CPU_n = 1'b1; RW_n = 1'b1; BR_68SEC000_n = 1'b1;
      REGION_HIT = 2'b00; REGION_WS = 6'd0; DTACK_MB_n = 1'b1;
      #1 RESET = 1'b1;
      #2;
      n_checks++;
      if (obs !== 4'b1110) begin
         n_errors++;
         $display("FAIL reset_state: outputs=%b required=1110", obs);
      end
      step(); step();
      RESET = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         step();
         n_checks++;
         if (obs !== 4'b1110) begin
            n_errors++;
            $display("FAIL post_reset_idle[%0d]: outputs=%b required=1110", n, obs);
         end
      end
   endtask

   // Region 0 (WS=1) wins over region 1 (WS=5); then a back-to-back region-1 cycle
   task automatic test_fast_back_to_back();
      logic [3:0] exp_v;
      REGION_HIT = 2'b11;
      REGION_WS  = {3'd5, 3'd1};
      AS_CPU_n   = 1'b0;
      for (int n = 1; n <= 13; n++) begin
         step();
         if (n <= 2)       exp_v = 4'b1111;
         else if (n <= 4)  exp_v = 4'b1011;
         else if (n == 5)  exp_v = 4'b1110;
         else if (n <= 11) exp_v = 4'b1111;
         else if (n == 12) exp_v = 4'b1011;
         else              exp_v = 4'b1110;
         n_checks++;
         if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL fast_cycle[%0d]: outputs=%b required=%b", n, obs, exp_v);
         end
         if (n == 1)       REGION_HIT = 2'b10;
         else if (n == 4)  AS_CPU_n = 1'b1;
         else if (n == 5)  AS_CPU_n = 1'b0;
         else if (n == 12) AS_CPU_n = 1'b1;
         else              AS_CPU_n = AS_CPU_n;
      end
      idle(2);
   endtask

   task automatic test_fast_abort();
      logic [3:0] exp_v;
      REGION_HIT = 2'b01;
      REGION_WS  = {3'd0, 3'd7};
      AS_CPU_n   = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         step();
         exp_v = (n <= 3) ? 4'b1111 : 4'b1110;
         n_checks++;
         if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL fast_abort[%0d]: outputs=%b required=%b", n, obs, exp_v);
         end
         if (n == 3) AS_CPU_n = 1'b1;
      end
      idle(2);
   endtask

   // C7M = CLKCPU/6 driven from edge 0; sync'd rises act on edges 6, 12, 18, ...
   task automatic test_mb_dtack();
      logic [3:0] exp_v;
      REGION_HIT = 2'b00;
      AS_CPU_n   = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         step();
         if (n <= 5)       exp_v = 4'b1111;
         else if (n <= 17) exp_v = 4'b0111;
         else if (n <= 19) exp_v = 4'b0011;
         else              exp_v = 4'b1110;
         n_checks++;
         if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL mb_dtack[%0d]: outputs=%b required=%b", n, obs, exp_v);
         end
         C7M        = ((n % 6) >= 3) ? 1'b1 : 1'b0;
         DTACK_MB_n = (n >= 13 && n < 19) ? 1'b0 : 1'b1;
         AS_CPU_n   = (n >= 19) ? 1'b1 : 1'b0;
      end
      idle(6);
   endtask

   // dtack_from < 0: DTACK_MB_n never asserts; otherwise it lands on the 8th counted rise
   task automatic test_mb_timeout(input int dtack_from, input logic [3:0] term_v);
      logic [3:0] exp_v;
      REGION_HIT = 2'b00;
      AS_CPU_n   = 1'b0;
      for (int n = 1; n <= 56; n++) begin
         step();
         if (n <= 5)       exp_v = 4'b1111;
         else if (n <= 53) exp_v = 4'b0111;
         else if (n <= 55) exp_v = term_v;
         else              exp_v = 4'b1110;
         n_checks++;
         if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL mb_timeout(dtack_from=%0d)[%0d]: outputs=%b required=%b",
                     dtack_from, n, obs, exp_v);
         end
         C7M        = ((n % 6) >= 3) ? 1'b1 : 1'b0;
         DTACK_MB_n = (dtack_from >= 0 && n >= dtack_from && n < 55) ? 1'b0 : 1'b1;
         AS_CPU_n   = (n >= 55) ? 1'b1 : 1'b0;
      end
      idle(6);
   endtask

   task automatic test_reset_mid_mb();
      REGION_HIT = 2'b00;
      AS_CPU_n   = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         step();
         C7M = ((n % 6) >= 3) ? 1'b1 : 1'b0;
      end
      n_checks++;
      if (obs !== 4'b0111) begin
         n_errors++;
         $display("FAIL reset_mid_mb_pre: outputs=%b required=0111", obs);
      end
      #2 RESET = 1'b1;
      #1;
      n_checks++;
      if (obs !== 4'b1110) begin
         n_errors++;
         $display("FAIL reset_mid_mb_async: outputs=%b required=1110", obs);
      end
      #1 RESET = 1'b0;
      AS_CPU_n = 1'b1;
      C7M      = 1'b0;
      step();
      n_checks++;
      if (obs !== 4'b1110) begin
         n_errors++;
         $display("FAIL reset_mid_mb_idle: outputs=%b required=1110", obs);
      end
      idle(4);
   endtask

   task automatic test_bus_granted();
      int bad = 0;
      BR_68SEC000_n = 1'b0;
      REGION_HIT    = 2'b00;
      AS_CPU_n      = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         step();
         n_checks++;
         if (obs !== 4'b1110) begin
            n_errors++;
            if (bad < 5) $display("FAIL bus_granted[%0d]: outputs=%b required=1110", n, obs);
            bad++;
         end
         C7M = ((n % 6) >= 3) ? 1'b1 : 1'b0;
      end
      BR_68SEC000_n = 1'b1;
      idle(6);
   endtask

   initial begin
      test_reset();
      test_fast_back_to_back();
      test_fast_abort();
      test_mb_dtack();
      test_mb_timeout(-1, 4'b0101);
      test_mb_timeout(51, 4'b0011);
      test_reset_mid_mb();
      test_bus_granted();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
